// File: rtl/clock_divider_pkg.sv
// Shared constants and period helpers for the multi-channel clock divider.
// Helpers work on a fixed 32-bit calculation width; callers zero-extend counters.
package clock_divider_pkg;

  localparam int DEFAULT_CNT_W = 24;
  localparam int CALC_W        = 32;

  // Periods below 2 cannot toggle, so they are clamped to 2.
  function automatic logic [CALC_W-1:0] eff_period(input logic [CALC_W-1:0] p);
    return (p < CALC_W'(2)) ? CALC_W'(2) : p;
  endfunction

  function automatic logic [CALC_W-1:0] half(input logic [CALC_W-1:0] p);
    return p >> 1;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, active/shadow config, pending flag, registered outputs.
// CLOCK_DIVIDER_DUTY_EN selects a programmable high time; otherwise duty is 50%.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int          CNT_W          = DEFAULT_CNT_W,
  parameter int unsigned DEFAULT_PERIOD = 12000000,
  parameter int unsigned DEFAULT_HIGH   = 6000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_high,
  output logic             pending,
  output logic             div_clock,
  output logic             tick
);

  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic [CNT_W-1:0]  active_period_reg;
  logic [CNT_W-1:0]  shadow_period_reg;
  logic              pending_reg;
  logic              pending_next;
  logic              div_clock_reg;
  logic              tick_reg;
  logic [CALC_W-1:0] cnt_w;
  logic [CALC_W-1:0] period_w;
  logic [CALC_W-1:0] high_w;
  logic              wrap;
  logic              load_shadow;
  logic              load_active;
  logic              apply_shadow;

  assign cnt_w    = CALC_W'(cnt_reg);
  assign period_w = eff_period(CALC_W'(active_period_reg));
  assign wrap     = en & (cnt_w >= period_w - CALC_W'(1));

  // A running channel defers new config to its boundary; a stopped one takes it at once.
  assign load_shadow  = wr & en;
  assign load_active  = wr & ~en;
  assign apply_shadow = pending_reg & (wrap | ~en);

  always_comb begin
    cnt_next     = '0;
    pending_next = pending_reg;
    if (en && !wrap) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
    if (apply_shadow) begin
      pending_next = 1'b0;
    end
    if (load_shadow) begin
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg           <= '0;
      pending_reg       <= 1'b0;
      div_clock_reg     <= 1'b0;
      tick_reg          <= 1'b0;
      active_period_reg <= CNT_W'(DEFAULT_PERIOD);
      shadow_period_reg <= CNT_W'(DEFAULT_PERIOD);
    end else begin
      cnt_reg       <= cnt_next;
      pending_reg   <= pending_next;
      div_clock_reg <= en & (cnt_w < high_w);
      tick_reg      <= en & (cnt_reg == '0);
      if (load_shadow) begin
        shadow_period_reg <= wr_period;
      end
      if (load_active) begin
        active_period_reg <= wr_period;
      end else if (apply_shadow) begin
        active_period_reg <= shadow_period_reg;
      end
    end
  end

`ifdef CLOCK_DIVIDER_DUTY_EN
  logic [CNT_W-1:0] active_high_reg;
  logic [CNT_W-1:0] shadow_high_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      active_high_reg <= CNT_W'(DEFAULT_HIGH);
      shadow_high_reg <= CNT_W'(DEFAULT_HIGH);
    end else begin
      if (load_shadow) begin
        shadow_high_reg <= wr_high;
      end
      if (load_active) begin
        active_high_reg <= wr_high;
      end else if (apply_shadow) begin
        active_high_reg <= shadow_high_reg;
      end
    end
  end

  assign high_w = CALC_W'(active_high_reg);
`else
  logic unused_high_cfg;
  assign unused_high_cfg = ^{wr_high, CNT_W'(DEFAULT_HIGH)};
  assign high_w          = half(period_w);
`endif

  assign pending   = pending_reg;
  assign div_clock = div_clock_reg;
  assign tick      = tick_reg;

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent programmable clock dividers behind one valid/ready config port.
// Define CLOCK_DIVIDER_DUTY_EN to enable per-channel programmable high time.
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = DEFAULT_CNT_W,
  parameter int unsigned DEFAULT_PERIOD = 12000000,
  parameter int unsigned DEFAULT_HIGH   = 6000000,
  localparam int         CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] div_clock,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0]    pending;
  logic [NUM_CH-1:0]    wr;
  logic [(1<<CH_W)-1:0] pending_pad;

  // Unused channel indices read as not pending, so writes to them are accepted and dropped.
  always_comb begin
    pending_pad             = '0;
    pending_pad[NUM_CH-1:0] = pending;
  end

  assign cfg_ready = ~pending_pad[cfg_ch];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign wr[gi] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(gi));

      clock_divider_channel #(
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD),
        .DEFAULT_HIGH   (DEFAULT_HIGH)
      ) u_ch (
        .clock     (clock),
        .reset     (reset),
        .en        (enable[gi]),
        .wr        (wr[gi]),
        .wr_period (cfg_period),
        .wr_high   (cfg_high),
        .pending   (pending[gi]),
        .div_clock (div_clock[gi]),
        .tick      (tick[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: stimulus queues per-cycle expectations,
// a monitor sampling just after each rising edge pops and compares them.
module tb_clock_divider_multi;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] enable;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_period;
  logic [7:0] cfg_high;
  logic [3:0] div_clock;
  logic [3:0] tick;

  clock_divider_multi #(
    .NUM_CH         (4),
    .CNT_W          (8),
    .DEFAULT_PERIOD (8),
    .DEFAULT_HIGH   (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .div_clock  (div_clock),
    .tick       (tick)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         due;
    string      name;
    int         idx;
    logic [3:0] mask;
    logic [3:0] e_div;
    logic [3:0] e_tick;
    bit         chk_rdy;
    logic       e_rdy;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Monitor: outputs settle after the edge; inputs were set on the previous falling edge.
  always @(posedge clock) begin
    cyc = cyc + 1;
    #2;
    while (q.size() > 0 && q[0].due <= cyc) begin
      m = q.pop_front();
      n_checks++;
      if (m.due != cyc) begin
        $display("FAIL %s[%0d]: checked at cycle %0d, required cycle %0d", m.name, m.idx, cyc, m.due);
      end else if (((div_clock & m.mask) !== m.e_div) || ((tick & m.mask) !== m.e_tick) ||
                   (m.chk_rdy && (cfg_ready !== m.e_rdy))) begin
        $display("FAIL %s[%0d] cycle %0d: div=%b tick=%b rdy=%b, required div=%b tick=%b rdy=%b (mask %b)",
                 m.name, m.idx, cyc, div_clock & m.mask, tick & m.mask, cfg_ready,
                 m.e_div, m.e_tick, m.chk_rdy ? m.e_rdy : cfg_ready, m.mask);
      end else begin
        n_pass++;
        $display("check %s[%0d] cycle %0d ok: div=%b tick=%b rdy=%b", m.name, m.idx, cyc,
                 div_clock & m.mask, tick & m.mask, cfg_ready);
      end
    end
  end

  // One expectation per cycle; masked channels not named by cha/chb must read 0.
  task automatic play(input string nm, input logic [3:0] mask,
                      input int cha, input string da, input string ta,
                      input int chb, input string db, input string tbs,
                      input string rp);
    for (int i = 0; i < da.len(); i++) begin
      exp_t e;
      e.due     = cyc + 1;
      e.name    = nm;
      e.idx     = i;
      e.mask    = mask;
      e.e_div   = '0;
      e.e_tick  = '0;
      e.e_div[cha]  = (da[i] == "1");
      e.e_tick[cha] = (ta[i] == "1");
      if (chb >= 0) begin
        e.e_div[chb]  = (db[i] == "1");
        e.e_tick[chb] = (tbs[i] == "1");
      end
      e.chk_rdy = (rp[i] != "x");
      e.e_rdy   = (rp[i] == "1");
      q.push_back(e);
      @(negedge clock);
    end
  endtask

  task automatic cfg(input logic v, input logic [1:0] ch, input int p, input int h);
    cfg_valid  = v;
    cfg_ch     = ch;
    cfg_period = 8'(p);
    cfg_high   = 8'(h);
  endtask

  string d_h0, d_h7, d_pre, d_pend;

  initial begin
    reset      = 1'b1;
    enable     = 4'b0000;
    cfg(1'b0, 2'd0, 0, 0);
`ifdef CLOCK_DIVIDER_DUTY_EN
    d_h0   = "00000000";
    d_h7   = "1111111111";
    d_pre  = "11";
    d_pend = "1";
`else
    d_h0   = "11001100";
    d_h7   = "1100011000";
    d_pre  = "11";
    d_pend = "0";
`endif
    @(negedge clock);
    play("reset", 4'hF, 0, "00", "00", -1, "", "", "11");
    reset = 1'b0;

    // ch0: direct write while stopped, then period 4 / high 2
    cfg(1'b1, 2'd0, 4, 2);
    play("cfg_direct", 4'hF, 0, "0", "0", -1, "", "", "1");
    cfg(1'b0, 2'd0, 4, 2);
    enable = 4'b0001;
    play("ch0_p4", 4'hF, 0, "110011001100", "100010001000", -1, "", "", "111111111111");
    play("ch0_p4_mid", 4'h1, 0, "11", "10", -1, "", "", "11");

    // ch0: mid-period write of period 6 / high 3
    cfg(1'b1, 2'd0, 6, 3);
    play("ch0_wr", 4'h1, 0, "0", "0", -1, "", "", "0");
    cfg(1'b0, 2'd0, 6, 3);
    play("ch0_p6", 4'h1, 0, "0111000111000", "0100000100000", -1, "", "", "1111111111111");

    // ch1 stalled second write, ch2 accepted in the same window
    cfg(1'b0, 2'd1, 0, 0);
    enable = 4'b0111;
    play("ch12_run", 4'h6, 1, "11", "10", 2, "11", "10", "11");
    cfg(1'b1, 2'd1, 3, 1);
    play("ch1_wr1", 4'h6, 1, "1", "0", 2, "1", "0", "0");
    cfg(1'b0, 2'd2, 3, 1);
    play("ch2_rdy", 4'h6, 1, "1", "0", 2, "1", "0", "1");
    cfg(1'b1, 2'd2, 5, 2);
    play("ch2_wr", 4'h6, 1, "0", "0", 2, "0", "0", "0");
    cfg(1'b1, 2'd1, 2, 1);
    play("ch1_stall", 4'h6, 1, "0001", "0001", 2, "0001", "0001", "0010");
    cfg(1'b0, 2'd1, 2, 1);
    play("ch1_p3p2", 4'h6, 1, "00101", "00101", 2, "10001", "00001", "01111");

    // ch3 limits: period 0 and 1 run as 2, high 0, high 7 over period 5
    cfg(1'b1, 2'd3, 0, 1);
    play("ch3_p0_wr", 4'h8, 3, "0", "0", -1, "", "", "1");
    cfg(1'b0, 2'd3, 0, 1);
    enable = 4'b1111;
    play("ch3_p0", 4'h8, 3, "101010", "101010", -1, "", "", "111111");
    enable[3] = 1'b0;
    cfg(1'b1, 2'd3, 1, 1);
    play("ch3_p1_wr", 4'h8, 3, "0", "0", -1, "", "", "1");
    cfg(1'b0, 2'd3, 1, 1);
    enable[3] = 1'b1;
    play("ch3_p1", 4'h8, 3, "101010", "101010", -1, "", "", "111111");
    enable[3] = 1'b0;
    cfg(1'b1, 2'd3, 4, 0);
    play("ch3_h0_wr", 4'h8, 3, "0", "0", -1, "", "", "1");
    cfg(1'b0, 2'd3, 4, 0);
    enable[3] = 1'b1;
    play("ch3_h0", 4'h8, 3, d_h0, "10001000", -1, "", "", "11111111");
    enable[3] = 1'b0;
    cfg(1'b1, 2'd3, 5, 7);
    play("ch3_h7_wr", 4'h8, 3, "0", "0", -1, "", "", "1");
    cfg(1'b0, 2'd3, 5, 7);
    enable[3] = 1'b1;
    play("ch3_h7", 4'h8, 3, d_h7, "1000010000", -1, "", "", "1111111111");

    // ch3: pending write, enable drop applies it, re-enable 3 cycles later
    play("ch3_pre", 4'h8, 3, d_pre, "10", -1, "", "", "11");
    cfg(1'b1, 2'd3, 4, 2);
    play("ch3_pend", 4'h8, 3, d_pend, "0", -1, "", "", "0");
    cfg(1'b0, 2'd3, 4, 2);
    enable[3] = 1'b0;
    play("ch3_off", 4'h8, 3, "000", "000", -1, "", "", "111");
    enable[3] = 1'b1;
    play("ch3_on", 4'h8, 3, "11001100", "10001000", -1, "", "", "11111111");

    repeat (4) @(negedge clock);
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
